// File: rtl/ocd_vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG scan initiator: FSM states,
// OCI virtual IR codes and default scan widths.
package ocd_vjtag_pkg;

    localparam int DR_W = 38;
    localparam int IR_W = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RESP
    } state_t;

endpackage

// File: rtl/ocd_vjtag_scan_initiator_if.sv
// Command/response handshake bundle between a requester and the scan initiator.
interface ocd_vjtag_scan_initiator_if #(
    parameter int DR_W = ocd_vjtag_pkg::DR_W,
    parameter int IR_W = ocd_vjtag_pkg::IR_W
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic            cmd_dr_en;
    logic [DR_W-1:0] cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_data;
    logic [IR_W-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr_en, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr_en, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );
endinterface

// File: rtl/ocd_vjtag_tck_gen.sv
// tck generator: half-period divider, tck level, rise/fall enables and a
// per-state tck period counter that flags the last falling edge of a state.
module ocd_vjtag_tck_gen #(
    parameter int TCK_DIV = 2,
    parameter int PW      = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          active,
    input  logic [PW-1:0] period_len,
    output logic          tck,
    output logic          rise,
    output logic          fall,
    output logic          period_done
);
    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [DW-1:0] div_reg;
    logic          tck_reg;
    logic [PW-1:0] period_reg;
    logic          half_end;

    assign half_end    = (div_reg == DW'(TCK_DIV - 1));
    assign rise        = active & half_end & ~tck_reg;
    assign fall        = active & half_end & tck_reg;
    assign period_done = fall & (period_reg == period_len - PW'(1));
    assign tck         = tck_reg;

    // Divider and period counter restart whenever the initiator is idle, so every
    // active state begins with tck low at the start of a fresh period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_reg    <= '0;
            tck_reg    <= 1'b0;
            period_reg <= '0;
        end else if (!active) begin
            div_reg    <= '0;
            tck_reg    <= 1'b0;
            period_reg <= '0;
        end else begin
            if (half_end) begin
                div_reg <= '0;
                tck_reg <= ~tck_reg;
            end else begin
                div_reg <= div_reg + DW'(1);
            end
            if (fall) begin
                period_reg <= period_done ? '0 : period_reg + PW'(1);
            end
        end
    end
endmodule

// File: rtl/ocd_vjtag_scan_initiator.sv
// Host-side virtual-JTAG initiator: one IR update plus optional DR scan per
// command, driving the OCI debug module's tck/tdi/ir_in and state strobes.
module ocd_vjtag_scan_initiator #(
    parameter int DR_W       = ocd_vjtag_pkg::DR_W,
    parameter int IR_W       = ocd_vjtag_pkg::IR_W,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ocd_vjtag_scan_initiator_if.slave bus,
    output logic                 vji_tck,
    output logic                 vji_tdi,
    input  logic                 vji_tdo,
    output logic [IR_W-1:0]      vji_ir_in,
    input  logic [IR_W-1:0]      vji_ir_out,
    output logic                 vji_uir,
    output logic                 vji_cdr,
    output logic                 vji_sdr,
    output logic                 vji_udr,
    output logic                 vji_rti
);
    import ocd_vjtag_pkg::*;

    localparam int MAXP = (DR_W > RTI_CYCLES) ? DR_W : RTI_CYCLES;
    localparam int PW   = $clog2(MAXP + 1);

    state_t          state_reg, state_next;
    logic [IR_W-1:0] ir_in_reg;
    logic            dr_en_reg;
    logic [DR_W-1:0] tx_reg;
    logic [DR_W-1:0] rx_reg;
    logic [IR_W-1:0] ir_out_reg;
    logic            rsp_valid_reg;
    logic            active;
    logic            accept;
    logic [PW-1:0]   period_len;
    logic            rise, fall, period_done;

    assign active = (state_reg != ST_IDLE) && (state_reg != ST_RESP);
    assign accept = (state_reg == ST_IDLE) && bus.cmd_valid;

    ocd_vjtag_tck_gen #(
        .TCK_DIV (TCK_DIV),
        .PW      (PW)
    ) u_tck_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .active      (active),
        .period_len  (period_len),
        .tck         (vji_tck),
        .rise        (rise),
        .fall        (fall),
        .period_done (period_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        period_len = PW'(1);
        case (state_reg)
            ST_IDLE: if (bus.cmd_valid) state_next = ST_UIR;
            ST_UIR:  if (period_done) state_next = dr_en_reg ? ST_CDR : ST_RTI;
            ST_CDR:  if (period_done) state_next = ST_SDR;
            ST_SDR: begin
                period_len = PW'(DR_W);
                if (period_done) state_next = ST_UDR;
            end
            ST_UDR:  if (period_done) state_next = ST_RTI;
            ST_RTI: begin
                period_len = PW'(RTI_CYCLES);
                if (period_done) state_next = ST_RESP;
            end
            ST_RESP: if (rsp_valid_reg && bus.rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // rx is cleared at accept so an IR-only command reports an all-zero word;
    // tdo is captured on tck rise, tdi advances on tck fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_in_reg     <= '0;
            dr_en_reg     <= 1'b0;
            tx_reg        <= '0;
            rx_reg        <= '0;
            ir_out_reg    <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                ir_in_reg <= bus.cmd_ir;
                dr_en_reg <= bus.cmd_dr_en;
                tx_reg    <= bus.cmd_data;
                rx_reg    <= '0;
            end
            if (rise && state_reg == ST_UIR) ir_out_reg <= vji_ir_out;
            if (rise && state_reg == ST_SDR) rx_reg <= {vji_tdo, rx_reg[DR_W-1:1]};
            if (fall && state_reg == ST_SDR) tx_reg <= {1'b0, tx_reg[DR_W-1:1]};
            if (state_reg == ST_RESP && !rsp_valid_reg) begin
                rsp_valid_reg <= 1'b1;
            end else if (rsp_valid_reg && bus.rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = (state_reg == ST_IDLE);
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rx_reg;
    assign bus.rsp_ir_out = ir_out_reg;

    assign vji_ir_in = ir_in_reg;
    assign vji_tdi   = (state_reg == ST_SDR) & tx_reg[0];
    assign vji_uir   = (state_reg == ST_UIR);
    assign vji_cdr   = (state_reg == ST_CDR);
    assign vji_sdr   = (state_reg == ST_SDR);
    assign vji_udr   = (state_reg == ST_UDR);
    assign vji_rti   = (state_reg == ST_RTI);
endmodule

// File: tb/tb_ocd_vjtag_scan_initiator.sv
// Directed table-driven bench for the virtual-JTAG scan initiator.
module tb_ocd_vjtag_scan_initiator;
    localparam int DRW = 38;
    localparam int IRW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ocd_vjtag_scan_initiator_if #(.DR_W(DRW), .IR_W(IRW)) bus ();

    logic           vji_tck, vji_tdi, vji_tdo;
    logic [IRW-1:0] vji_ir_in, vji_ir_out;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic           tdo_loop, tdo_const;

    assign vji_tdo = tdo_loop ? vji_tdi : tdo_const;

    ocd_vjtag_scan_initiator #(
        .DR_W(DRW), .IR_W(IRW), .TCK_DIV(2), .RTI_CYCLES(1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_tdo    (vji_tdo),
        .vji_ir_in  (vji_ir_in),
        .vji_ir_out (vji_ir_out),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti)
    );

    typedef struct {
        logic [1:0]  ir;
        logic        dr_en;
        logic [37:0] data;
        logic        loop;
        logic        tdo_val;
        logic [1:0]  tgt_ir_out;
        logic [37:0] exp_data;
        logic [1:0]  exp_ir_out;
        int          exp_lat;
        int          exp_sdr;
        int          exp_cdr;
        int          exp_tck_hi;
    } vec_t;

    vec_t vecs[5];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input vec_t v);
        int w = 0;
        tdo_loop   = v.loop;
        tdo_const  = v.tdo_val;
        vji_ir_out = v.tgt_ir_out;
        while (!bus.cmd_ready && w < 500) begin
            tick;
            w++;
        end
        check("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = v.ir;
        bus.cmd_dr_en = v.dr_en;
        bus.cmd_data  = v.data;
        tick;
        bus.cmd_valid = 1'b0;
        check("ready_low_after_accept", bus.cmd_ready, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx, input int bp_cycles);
        int cnt = 0, n_sdr = 0, n_cdr = 0, n_udr = 0, n_uir = 0, n_tck = 0, n_tdi_out = 0;
        int bad = 0;
        logic [37:0] snap;
        start_cmd(v);
        while (!bus.rsp_valid && cnt < 400) begin
            n_sdr += int'(vji_sdr);
            n_cdr += int'(vji_cdr);
            n_udr += int'(vji_udr);
            n_uir += int'(vji_uir);
            n_tck += int'(vji_tck);
            if (vji_tdi && !vji_sdr) n_tdi_out++;
            tick;
            cnt++;
        end
        $display("[TB] vec %0d ir=%b dr_en=%0d lat=%0d rsp_data=%h ir_out=%b",
                 idx, v.ir, v.dr_en, cnt, bus.rsp_data, bus.rsp_ir_out);
        check($sformatf("v%0d_latency", idx), cnt, v.exp_lat);
        check($sformatf("v%0d_rsp_data", idx), bus.rsp_data, v.exp_data);
        check($sformatf("v%0d_rsp_ir_out", idx), bus.rsp_ir_out, v.exp_ir_out);
        check($sformatf("v%0d_ir_in", idx), vji_ir_in, v.ir);
        check($sformatf("v%0d_uir_clk", idx), n_uir, 4);
        check($sformatf("v%0d_sdr_clk", idx), n_sdr, v.exp_sdr);
        check($sformatf("v%0d_cdr_clk", idx), n_cdr, v.exp_cdr);
        check($sformatf("v%0d_udr_clk", idx), n_udr, v.exp_cdr);
        check($sformatf("v%0d_tck_high_clk", idx), n_tck, v.exp_tck_hi);
        check($sformatf("v%0d_tdi_outside_sdr", idx), n_tdi_out, 0);
        check($sformatf("v%0d_tck_in_resp", idx), vji_tck, 0);
        if (bp_cycles > 0) begin
            snap = bus.rsp_data;
            bus.cmd_valid = 1'b1;
            bus.cmd_ir    = ~v.ir;
            bus.cmd_data  = ~v.data;
            bus.cmd_dr_en = 1'b1;
            for (int i = 0; i < bp_cycles; i++) begin
                tick;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== snap || vji_tck !== 1'b0 ||
                    bus.cmd_ready !== 1'b0 || vji_ir_in !== v.ir) bad++;
            end
            bus.cmd_valid = 1'b0;
            $display("[TB] backpressure %0d clk, unstable samples=%0d", bp_cycles, bad);
            check("backpressure_stable", bad, 0);
        end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_valid_cleared", idx), bus.rsp_valid, 0);
        check($sformatf("v%0d_ready_after_rsp", idx), bus.cmd_ready, 1);
    endtask

    initial begin
        int bad;
        int n;
        vecs[0] = '{2'b10, 1'b1, 38'h2A_5A5A_A5A5, 1'b1, 1'b0, 2'b01, 38'h2A_5A5A_A5A5, 2'b01, 169, 152, 4, 84};
        vecs[1] = '{2'b00, 1'b1, 38'h00_0000_0000, 1'b0, 1'b1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10, 169, 152, 4, 84};
        vecs[2] = '{2'b01, 1'b0, 38'h00_0001_2345, 1'b0, 1'b1, 2'b11, 38'h00_0000_0000, 2'b11, 9,   0,   0, 4};
        vecs[3] = '{2'b11, 1'b1, 38'h01_0000_0001, 1'b1, 1'b0, 2'b00, 38'h01_0000_0001, 2'b00, 169, 152, 4, 84};
        vecs[4] = '{2'b00, 1'b1, 38'h3F_FFFF_FFFF, 1'b0, 1'b0, 2'b01, 38'h00_0000_0000, 2'b01, 169, 152, 4, 84};

        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = 2'b11;
        bus.cmd_dr_en = 1'b1;
        bus.cmd_data  = '1;
        bus.rsp_ready = 1'b0;
        tdo_loop      = 1'b0;
        tdo_const     = 1'b1;
        vji_ir_out    = 2'b11;

        // Held in reset with a pending command: nothing may move.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 ||
                bus.rsp_ir_out !== '0 || vji_tck !== 1'b0 || vji_tdi !== 1'b0 || vji_ir_in !== '0 ||
                {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 5'b0) bad++;
        end
        $display("[TB] reset hold 20 clk, bad samples=%0d", bad);
        check("reset_outputs", bad, 0);
        bus.cmd_valid = 1'b0;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || vji_tck !== 1'b0) bad++;
        end
        $display("[TB] post-reset idle 20 clk, bad samples=%0d", bad);
        check("post_reset_idle", bad, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i, (i == 1) ? 50 : 0);

        // Abort in the middle of the 18th SDR bit, then prove recovery.
        start_cmd(vecs[0]);
        n = 0;
        for (int i = 0; i < 400 && n < 17 * 4 + 2; i++) begin
            if (vji_sdr) n++;
            tick;
        end
        check("reached_sdr_bit17", n, 17 * 4 + 2);
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] async reset mid-SDR: ready=%0d tck=%0d sdr=%0d ir_in=%b",
                 bus.cmd_ready, vji_tck, vji_sdr, vji_ir_in);
        check("midreset_ready", bus.cmd_ready, 1);
        check("midreset_strobes_tck_tdi",
              {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
        check("midreset_ir_in", vji_ir_in, 0);
        check("midreset_rsp", {bus.rsp_valid, bus.rsp_data}, 0);
        tick;
        tick;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.rsp_valid !== 1'b0) bad++;
        end
        check("no_rsp_after_abort", bad, 0);
        run_vec(vecs[0], 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
